// File: rtl/iddmm_word_engine.sv
// iddmm_word_engine
//   Word-serial CIOS Montgomery multiplier: R = X*Y*2^(-K*N) mod P.
//   Operands are loaded word by word into internal buffers, a start pulse
//   runs N outer iterations of (multiply pass, quotient, reduce pass), a
//   final subtract pass picks A or A-P, and the reduced result is streamed
//   out LSW first under valid/ready.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   op_wr_en/sel/addr/data     operand word write (0=X, 1=Y, 2=P, 3=dropped);
//                              ignored while busy
//   p1                         -P^(-1) mod 2^K, held stable while busy
//   start                      begin a computation (accepted only in IDLE)
//   busy                       computation / result streaming in progress
//   res_valid/ready/data/last  result word stream, res_last on word N-1
//   res_sel                    1 when A-P was selected as the result
//   done                       single-cycle pulse after the last word is taken
module iddmm_word_engine #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_wr_en,
  input  logic [1:0]        op_wr_sel,
  input  logic [ADDR_W-1:0] op_wr_addr,
  input  logic [K-1:0]      op_wr_data,
  input  logic [K-1:0]      p1,
  input  logic              start,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [K-1:0]      res_data,
  output logic              res_last,
  output logic              res_sel,
  output logic              done
);

  typedef enum logic [3:0] {
    S_IDLE, S_MULX, S_MULX_TOP, S_QCALC, S_RED, S_RED_TOP, S_SUB, S_OUT, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   i_q, i_d, j_q, j_d;
  logic [K-1:0]        c_q, c_d, m_q, m_d;
  logic                borrow_q, borrow_d;
  logic [K-1:0]        a_q [N];
  logic [K-1:0]        a_d [N];
  logic [K-1:0]        a_n_q, a_n_d;       // A[N]
  logic                a_top_q, a_top_d;   // A[N+1]
  logic [K-1:0]        d_q [N];
  logic [K-1:0]        d_d [N];
  logic [K-1:0]        x_q [N];
  logic [K-1:0]        x_d [N];
  logic [K-1:0]        y_q [N];
  logic [K-1:0]        y_d [N];
  logic [K-1:0]        p_q [N];
  logic [K-1:0]        p_d [N];
  logic                busy_q, busy_d, res_valid_q, res_valid_d;
  logic [K-1:0]        res_data_q, res_data_d;
  logic                res_last_q, res_last_d, res_sel_q, res_sel_d;
  logic                done_q, done_d;

  logic [K-1:0]        mul_a, mul_b;
  logic [2*K-1:0]      prod, mac;
  logic [K:0]          top_sum, diff;
  logic                j_last, sel_new;
  logic [ADDR_W-1:0]   j_nxt;

  function automatic logic [K-1:0] pick(input logic sel, input logic [K-1:0] dw,
                                        input logic [K-1:0] aw);
    return sel ? dw : aw;
  endfunction

  // One shared K x K multiplier: X[i]*Y[j] in MULX, A[0]*p1 in QCALC,
  // m*P[j] in RED.
  always_comb begin
    mul_a = x_q[i_q];
    mul_b = y_q[j_q];
    case (state_q)
      S_QCALC: begin mul_a = a_q[0]; mul_b = p1;       end
      S_RED:   begin mul_a = m_q;    mul_b = p_q[j_q]; end
      default: ;
    endcase
  end

  // The sum A[j] + a*b + C never exceeds 2^(2K)-1, so 2K bits are exact.
  assign prod    = {{K{1'b0}}, mul_a} * {{K{1'b0}}, mul_b};
  assign mac     = prod + {{K{1'b0}}, a_q[j_q]} + {{K{1'b0}}, c_q};
  assign top_sum = {1'b0, a_n_q} + {1'b0, c_q};
  assign diff    = {1'b0, a_q[j_q]} - {1'b0, p_q[j_q]} - {{K{1'b0}}, borrow_q};
  assign j_last  = (j_q == LAST);
  assign j_nxt   = j_q + ADDR_W'(1);

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    c_d         = c_q;
    m_d         = m_q;
    borrow_d    = borrow_q;
    a_d         = a_q;
    a_n_d       = a_n_q;
    a_top_d     = a_top_q;
    d_d         = d_q;
    x_d         = x_q;
    y_d         = y_q;
    p_d         = p_q;
    busy_d      = busy_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_last_d  = res_last_q;
    res_sel_d   = res_sel_q;
    done_d      = 1'b0;
    sel_new     = 1'b0;

    if (op_wr_en && !busy_q) begin
      case (op_wr_sel)
        2'd0:    x_d[op_wr_addr] = op_wr_data;
        2'd1:    y_d[op_wr_addr] = op_wr_data;
        2'd2:    p_d[op_wr_addr] = op_wr_data;
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d       = '{default: '0};
          a_n_d     = '0;
          a_top_d   = 1'b0;
          i_d       = '0;
          j_d       = '0;
          c_d       = '0;
          res_sel_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_MULX;
        end
      end
      S_MULX: begin
        a_d[j_q] = mac[K-1:0];
        c_d      = mac[2*K-1:K];
        if (j_last) begin
          j_d     = '0;
          state_d = S_MULX_TOP;
        end else begin
          j_d = j_nxt;
        end
      end
      S_MULX_TOP: begin
        a_n_d   = top_sum[K-1:0];
        a_top_d = top_sum[K];
        state_d = S_QCALC;
      end
      S_QCALC: begin
        m_d     = prod[K-1:0];
        c_d     = '0;
        j_d     = '0;
        state_d = S_RED;
      end
      S_RED: begin
        // Word 0 of the reduce pass is zero by choice of m; the rest shift down.
        if (j_q != '0) a_d[j_q - ADDR_W'(1)] = mac[K-1:0];
        c_d = mac[2*K-1:K];
        if (j_last) begin
          j_d     = '0;
          state_d = S_RED_TOP;
        end else begin
          j_d = j_nxt;
        end
      end
      S_RED_TOP: begin
        a_d[LAST] = top_sum[K-1:0];
        a_n_d     = {{(K-1){1'b0}}, a_top_q} + {{(K-1){1'b0}}, top_sum[K]};
        a_top_d   = 1'b0;
        c_d       = '0;
        j_d       = '0;
        if (i_q == LAST) begin
          borrow_d = 1'b0;
          state_d  = S_SUB;
        end else begin
          i_d     = i_q + ADDR_W'(1);
          state_d = S_MULX;
        end
      end
      S_SUB: begin
        d_d[j_q] = diff[K-1:0];
        borrow_d = diff[K];
        if (j_last) begin
          // A >= P when A has a non-zero top word or the subtraction did not borrow.
          sel_new     = (a_n_q != '0) | ~diff[K];
          res_sel_d   = sel_new;
          res_data_d  = pick(sel_new, d_q[0], a_q[0]);
          res_valid_d = 1'b1;
          res_last_d  = 1'b0;
          j_d         = '0;
          state_d     = S_OUT;
        end else begin
          j_d = j_nxt;
        end
      end
      S_OUT: begin
        if (res_ready) begin
          if (j_last) begin
            res_valid_d = 1'b0;
            res_last_d  = 1'b0;
            res_data_d  = '0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = S_DONE;
          end else begin
            j_d        = j_nxt;
            res_data_d = pick(res_sel_q, d_q[j_nxt], a_q[j_nxt]);
            res_last_d = (j_nxt == LAST);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_last_q  <= 1'b0;
      res_sel_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_last_q  <= res_last_d;
      res_sel_q   <= res_sel_d;
      done_q      <= done_d;
    end
  end

  // Datapath storage is not reset; A is cleared when a computation starts.
  always_ff @(posedge clk) begin
    c_q      <= c_d;
    m_q      <= m_d;
    borrow_q <= borrow_d;
    a_q      <= a_d;
    a_n_q    <= a_n_d;
    a_top_q  <= a_top_d;
    d_q      <= d_d;
    x_q      <= x_d;
    y_q      <= y_d;
    p_q      <= p_d;
  end

  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_last  = res_last_q;
  assign res_sel   = res_sel_q;
  assign done      = done_q;

endmodule

// File: tb/tb_iddmm_word_engine.sv
// Bench for iddmm_word_engine at K=8, N=2: vector table checked through a
// result scoreboard, plus cycle-exact latency, backpressure, busy-ignore and
// mid-run reset sequences.
module tb_iddmm_word_engine;

  localparam int K      = 8;
  localparam int N      = 2;
  localparam int ADDR_W = $clog2(N);
  localparam int KN     = K * N;
  localparam int T_V    = N * (2 * N + 3) + N + 1;
  localparam int T_D    = N * (2 * N + 3) + 2 * N + 1;
  localparam int NV     = 12;

  typedef struct {
    logic [KN-1:0] x, y, p, r;
  } vec_t;

  typedef struct {
    logic [K-1:0] data;
    logic         last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              op_wr_en;
  logic [1:0]        op_wr_sel;
  logic [ADDR_W-1:0] op_wr_addr;
  logic [K-1:0]      op_wr_data;
  logic [K-1:0]      p1;
  logic              start;
  logic              busy, res_valid, res_ready, res_last, res_sel, done;
  logic [K-1:0]      res_data;

  int   n_vec = 0;
  int   n_err = 0;
  int   cov_sel0 = 0, cov_sel1 = 0;
  exp_t sb[$];
  vec_t vtab [NV];

  iddmm_word_engine #(.K(K), .N(N), .ADDR_W(ADDR_W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .op_wr_en(op_wr_en), .op_wr_sel(op_wr_sel), .op_wr_addr(op_wr_addr),
    .op_wr_data(op_wr_data), .p1(p1), .start(start), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last), .res_sel(res_sel), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired got no_finish expected finish");
    $fatal(1, "watchdog");
  end

  // X*Y*2^(-KN) mod P by halving modulo an odd P.
  function automatic logic [KN-1:0] mont(input logic [KN-1:0] x, y, p);
    logic [2*KN:0] r, pp;
    pp = {{(KN+1){1'b0}}, p};
    r  = ({{(KN+1){1'b0}}, x} * {{(KN+1){1'b0}}, y}) % pp;
    for (int t = 0; t < KN; t++) begin
      if (r[0]) r = r + pp;
      r = r >> 1;
    end
    return r[KN-1:0];
  endfunction

  function automatic logic [K-1:0] calc_p1(input logic [K-1:0] p);
    logic [K-1:0] inv, two;
    inv = p;
    two = K'(2);
    for (int t = 0; t < 6; t++) inv = inv * (two - p * inv);
    return (~inv) + K'(1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input int a, input logic [K-1:0] d);
    op_wr_en   = 1'b1;
    op_wr_sel  = sel;
    op_wr_addr = ADDR_W'(a);
    op_wr_data = d;
    tick();
    op_wr_en   = 1'b0;
  endtask

  task automatic load(input vec_t v);
    for (int w = 0; w < N; w++) begin
      wr(2'd0, w, v.x[w*K +: K]);
      wr(2'd1, w, v.y[w*K +: K]);
      wr(2'd2, w, v.p[w*K +: K]);
    end
    wr(2'd3, 0, K'($urandom));
    p1 = calc_p1(v.p[K-1:0]);
  endtask

  task automatic push_exp(input logic [KN-1:0] r);
    exp_t e;
    for (int w = 0; w < N; w++) begin
      e.data = r[w*K +: K];
      e.last = (w == N - 1);
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int cnt;
    cnt = 0;
    while (!done && cnt < 400) begin
      tick();
      cnt++;
    end
    chk(nm, 32'(done), 32'd1);
    if (res_sel) cov_sel1++; else cov_sel0++;
    tick();
    chk({nm, "_sb_empty"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_busy"},      32'(busy),      32'd0);
    chk({nm, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({nm, "_res_data"},  32'(res_data),  32'd0);
    chk({nm, "_res_last"},  32'(res_last),  32'd0);
    chk({nm, "_res_sel"},   32'(res_sel),   32'd0);
    chk({nm, "_done"},      32'(done),      32'd0);
  endtask

  // Scoreboard: compare each accepted result word with the next expected one.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && res_valid && res_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_word got %h expected none", res_data);
      end else begin
        e = sb.pop_front();
        if (res_data !== e.data || res_last !== e.last) begin
          n_err++;
          $display("FAIL result_word got data=%h last=%b expected data=%h last=%b",
                   res_data, res_last, e.data, e.last);
        end
      end
    end
  end

  initial begin
    logic [KN-1:0] pr;
    logic [31:0]   t32;

    vtab[0] = '{x: 16'h1234, y: 16'h000F, p: 16'hFFF1, r: 16'h1234};
    vtab[1] = '{x: 16'h0000, y: 16'h5555, p: 16'hFFF1, r: 16'h0000};
    vtab[2] = '{x: 16'hFFF0, y: 16'h000F, p: 16'hFFF1, r: 16'hFFF0};
    for (int v = 3; v < NV; v++) begin
      pr  = KN'($urandom_range(65535, 3)) | KN'(1);
      if (v == 3) pr = 16'hFFFD;
      t32 = $urandom;
      vtab[v].x = KN'(t32 % 32'(pr));
      t32 = $urandom;
      vtab[v].y = KN'(t32 % 32'(pr));
      vtab[v].p = pr;
      vtab[v].r = mont(vtab[v].x, vtab[v].y, pr);
    end

    rst_n = 1'b0; op_wr_en = 1'b0; op_wr_sel = '0; op_wr_addr = '0;
    op_wr_data = '0; p1 = '0; start = 1'b0; res_ready = 1'b1;
    tick(); tick(); tick();
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Cycle-exact latency on the first vector; start is sampled in cycle 0.
    load(vtab[0]);
    push_exp(vtab[0].r);
    start = 1'b1;
    for (int c = 1; c <= T_D + 1; c++) begin
      tick();
      start = 1'b0;
      chk($sformatf("lat_busy_c%0d", c),  32'(busy),      32'(c >= 1 && c < T_D));
      chk($sformatf("lat_valid_c%0d", c), 32'(res_valid), 32'(c >= T_V && c < T_D));
      chk($sformatf("lat_last_c%0d", c),  32'(res_last),  32'(c == T_D - 1));
      chk($sformatf("lat_done_c%0d", c),  32'(done),      32'(c == T_D));
    end
    chk("lat_sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();

    // Table of vectors through the scoreboard.
    for (int v = 1; v < NV; v++) begin
      load(vtab[v]);
      push_exp(vtab[v].r);
      pulse_start();
      wait_done($sformatf("vec%0d_done", v));
    end

    // Backpressure: word 1 is held for 5 cycles, done slips by 5.
    load(vtab[2]);
    push_exp(vtab[2].r);
    start = 1'b1;
    for (int c = 1; c <= T_D + 7; c++) begin
      tick();
      start = 1'b0;
      res_ready = !(c >= T_V + 1 && c <= T_V + 5);
      if (c >= T_V + 1 && c <= T_V + 5) begin
        chk($sformatf("bp_valid_c%0d", c), 32'(res_valid), 32'd1);
        chk($sformatf("bp_data_c%0d", c),  32'(res_data),  32'h0FF);
      end
      chk($sformatf("bp_done_c%0d", c), 32'(done), 32'(c == T_D + 5));
    end
    res_ready = 1'b1;
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();

    // start and operand writes while busy are ignored.
    load(vtab[5]);
    push_exp(vtab[5].r);
    pulse_start();
    tick(); tick(); tick();
    start = 1'b1;
    op_wr_en = 1'b1; op_wr_sel = 2'd0; op_wr_addr = '0;
    op_wr_data = ~vtab[5].x[K-1:0];
    tick();
    start = 1'b0;
    op_wr_sel = 2'd2; op_wr_data = 8'h02;
    tick();
    op_wr_en = 1'b0;
    wait_done("busy_ign_done");
    push_exp(vtab[5].r);
    pulse_start();
    wait_done("busy_ign_rerun_done");

    // Asynchronous reset mid-computation, then restart on the same operands.
    load(vtab[6]);
    push_exp(vtab[6].r);
    pulse_start();
    for (int c = 2; c <= 7; c++) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("mid_rst");
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    push_exp(vtab[6].r);
    pulse_start();
    wait_done("rst_restart_done");

    $display("coverage res_sel0=%0d res_sel1=%0d", cov_sel0, cov_sel1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
